uart_rx_fifo: RTL and testbench

- Receive-side buffer placed directly downstream of the UART interface receiver.
- Accepts each received character together with its parity, framing and break status.
- Holds characters in a first-word-fall-through FIFO and raises the receive interrupts:
  - data-available at a programmable trigger level;
  - character timeout.
- Sits between the receiver's byte output and the host read path.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_fifo_core.sv | 63 ++++++
 rtl/uart_rx_fifo.sv | 110 +++++++++++
 tb/tb_uart_rx_fifo.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer: trigger encodings and the
// layout of one stored entry {bi, fe, pe, data}.
package uart_pkg;

  localparam logic [1:0] TRIG_1  = 2'b00;
  localparam logic [1:0] TRIG_4  = 2'b01;
  localparam logic [1:0] TRIG_8  = 2'b10;
  localparam logic [1:0] TRIG_14 = 2'b11;

  localparam int PE_BIT  = 8;
  localparam int FE_BIT  = 9;
  localparam int BI_BIT  = 10;
  localparam int ENTRY_W = 11;

  function automatic int trig_value(input logic [1:0] sel);
    case (sel)
      TRIG_1:  trig_value = 1;
      TRIG_4:  trig_value = 4;
      TRIG_8:  trig_value = 8;
      TRIG_14: trig_value = 14;
      default: trig_value = 1;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo_core.sv
// Generic synchronous first-word-fall-through register FIFO with flush.
// The head entry is presented combinationally and reads as zero when empty.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             push_ok,
  output logic             pop_ok
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A pop frees a slot in the same cycle, so a full FIFO can still take a write.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | pop_ok) & ~flush;

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: FWFT character FIFO with line-status tracking,
// overrun, trigger-level and character-timeout interrupts.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int AW            = 4,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  input  logic          wr_pe,
  input  logic          wr_fe,
  input  logic          wr_bi,
  input  logic          rd_en,
  input  logic          flush,
  input  logic          lsr_rd,
  input  logic          char_tick,
  input  logic [1:0]    trig_lvl,
  output logic [7:0]    rd_data,
  output logic          rd_pe,
  output logic          rd_fe,
  output logic          rd_bi,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          fifo_err,
  output logic          rda_int,
  output logic          cti_int
);

  localparam logic [2:0] TMO_MAX = 3'(TIMEOUT_CHARS);

  logic [ENTRY_W-1:0] head;
  logic               push_ok;
  logic               pop_ok;
  logic [AW:0]        err_cnt;
  logic [2:0]         tmo_cnt;
  logic               ovr_evt;

  uart_fifo_core #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_valid),
    .pop     (rd_en),
    .flush   (flush),
    .wr_data ({wr_bi, wr_fe, wr_pe, wr_data}),
    .rd_data (head),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .push_ok (push_ok),
    .pop_ok  (pop_ok)
  );

  assign rd_data = head[7:0];
  assign rd_pe   = head[PE_BIT];
  assign rd_fe   = head[FE_BIT];
  assign rd_bi   = head[BI_BIT];

  // Counting flagged entries keeps fifo_err exact without scanning the array.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      err_cnt <= '0;
    end else begin
      case ({push_ok & (wr_pe | wr_fe | wr_bi), pop_ok & (rd_pe | rd_fe | rd_bi)})
        2'b10:   err_cnt <= err_cnt + (AW+1)'(1);
        2'b01:   err_cnt <= err_cnt - (AW+1)'(1);
        default: err_cnt <= err_cnt;
      endcase
    end
  end

  assign fifo_err = (err_cnt != '0);

  // A new overrun event wins over a coincident line-status read.
  assign ovr_evt = wr_valid & full & ~rd_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (ovr_evt) begin
      overrun <= 1'b1;
    end else if (lsr_rd) begin
      overrun <= 1'b0;
    end
  end

  assign rda_int = (count >= (AW+1)'(trig_value(trig_lvl)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (push_ok || pop_ok || flush || empty) begin
      tmo_cnt <= '0;
    end else if (char_tick && (tmo_cnt != TMO_MAX)) begin
      tmo_cnt <= tmo_cnt + 3'd1;
    end
  end

  assign cti_int = (tmo_cnt == TMO_MAX) & ~empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for single-cycle behaviour
// plus hand sequences for overrun, timeout, flush and reset corner cases.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_pe = 1'b0, wr_fe = 1'b0, wr_bi = 1'b0;
  logic       rd_en = 1'b0, flush = 1'b0, lsr_rd = 1'b0, char_tick = 1'b0;
  logic [1:0] trig_lvl = 2'b00;
  logic [7:0] rd_data;
  logic       rd_pe, rd_fe, rd_bi, empty, full;
  logic [4:0] count;
  logic       overrun, fifo_err, rda_int, cti_int;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16), .AW(4), .TIMEOUT_CHARS(4)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_pe(wr_pe), .wr_fe(wr_fe), .wr_bi(wr_bi), .rd_en(rd_en),
    .flush(flush), .lsr_rd(lsr_rd), .char_tick(char_tick), .trig_lvl(trig_lvl),
    .rd_data(rd_data), .rd_pe(rd_pe), .rd_fe(rd_fe), .rd_bi(rd_bi),
    .empty(empty), .full(full), .count(count), .overrun(overrun),
    .fifo_err(fifo_err), .rda_int(rda_int), .cti_int(cti_int)
  );

  typedef struct {
    logic       rs;
    logic       wv;
    logic [7:0] wd;
    logic [2:0] flg;
    logic       re, fl, lsr, tk;
    logic [1:0] tr;
    logic [4:0] c;
    logic [7:0] d;
    logic [2:0] f;
    logic       ov, er, ra, ct;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic cyc(input logic rs, input logic wv, input logic [7:0] wd,
                     input logic [2:0] flg, input logic re, input logic fl,
                     input logic lsr, input logic tk);
    @(negedge clk);
    rst = rs; wr_valid = wv; wr_data = wd;
    {wr_bi, wr_fe, wr_pe} = flg;
    rd_en = re; flush = fl; lsr_rd = lsr; char_tick = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [4:0] c, input logic [7:0] d,
                           input logic [2:0] f, input logic ov, input logic er,
                           input logic ra, input logic ct);
    chk({tag, ".count"},    16'(count), 16'(c));
    chk({tag, ".empty"},    16'(empty), 16'(c == 5'd0));
    chk({tag, ".full"},     16'(full), 16'(c == 5'd16));
    chk({tag, ".rd_data"},  16'(rd_data), 16'(d));
    chk({tag, ".flags"},    16'({rd_bi, rd_fe, rd_pe}), 16'(f));
    chk({tag, ".overrun"},  16'(overrun), 16'(ov));
    chk({tag, ".fifo_err"}, 16'(fifo_err), 16'(er));
    chk({tag, ".rda_int"},  16'(rda_int), 16'(ra));
    chk({tag, ".cti_int"},  16'(cti_int), 16'(ct));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rs    wv    wd     flg     re    fl    lsr   tk    tr     | c      d      f       ov    er    ra    ct
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'h55, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd1, 8'h55, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd1, 8'h01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'h02, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd2, 8'h01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'h03, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd3, 8'h01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'h04, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd4, 8'h01, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 5'd3, 8'h02, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h3C, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd1, 8'h3C, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'h41, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd2, 8'h3C, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd1, 8'h41, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      trig_lvl = tbl[i].tr;
      cyc(tbl[i].rs, tbl[i].wv, tbl[i].wd, tbl[i].flg, tbl[i].re, tbl[i].fl, tbl[i].lsr, tbl[i].tk);
      expect_st($sformatf("vec%0d", i), tbl[i].c, tbl[i].d, tbl[i].f,
                tbl[i].ov, tbl[i].er, tbl[i].ra, tbl[i].ct);
    end

    // Character timeout: four idle ticks, saturation, then a pop clears it.
    trig_lvl = 2'b00;
    cyc(1'b1, 1'b1, 8'h77, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("tmo.wr", 5'd1, 8'h77, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("tmo.tick%0d", k), 16'(cti_int), 16'(k >= 4));
    end
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("tmo.pop", 5'd0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    // A write between ticks two and three restarts the timeout.
    cyc(1'b1, 1'b1, 8'h11, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 8'h22, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("rst_tmo.wr2", 5'd2, 8'h11, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("rst_tmo.tick%0d", k), 16'(cti_int), 16'(k == 4));
    end
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("rst_tmo.pop1", 5'd1, 8'h22, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("rst_tmo.pop2", 5'd0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill to full, then overrun behaviour.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1, 8'(16 + i), 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("fill.count%0d", i), 16'(count), 16'(i + 1));
    end
    expect_st("fill.full", 5'd16, 8'h10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'hAA, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("ovr.drop", 5'd16, 8'h10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'hAA, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("ovr.wrpop", 5'd16, 8'h11, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'hBB, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("ovr.lsr_coinc", 5'd16, 8'h11, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Drain and verify order: 0x11..0x1F then the 0xAA accepted alongside a pop.
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain.head%0d", k), 16'(rd_data), (k < 15) ? 16'(17 + k) : 16'h00AA);
      cyc(1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("drain.count%0d", k), 16'(count), 16'(15 - k));
    end
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("pop_empty", 5'd0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush with coincident write and pop; overrun must survive it.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 8'(128 + i), (i == 2) ? 3'b100 : ((i == 5) ? 3'b001 : 3'b000),
          1'b0, 1'b0, 1'b0, 1'b0);
    end
    expect_st("flush.pre", 5'd8, 8'h80, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'hCC, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("flush.post", 5'd0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("lsr.clear", 5'd0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of activity discards everything.
    cyc(1'b1, 1'b1, 8'h61, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h62, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h63, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_st("mid.pre", 5'd3, 8'h61, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 8'h64, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("mid.reset", 5'd0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h5A, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("mid.after", 5'd1, 8'h5A, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("mid.pop", 5'd0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
